// File: rtl/descriptor_pkg.sv
// ---------------------------------------------------------------------------
// descriptor_pkg
// Shared types and constants for the descriptor generator / streamer pair.
//   streamer_state_t   : FSM states of descriptor_streamer
//   SYNC_BYTE          : first byte of the optional stream header
//   DEFAULT_DESC_WIDTH : histogram word width (8 bins x 3 bits)
// Optional feature macro: DESCRIPTOR_STREAM_HEADER_EN adds the HEADER state.
// ---------------------------------------------------------------------------
package descriptor_pkg;

  localparam int DEFAULT_DESC_WIDTH = 24;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Header layout: sync byte followed by the word count as 16 bits.
  localparam int HEADER_BYTES = 3;
  localparam int HEADER_WIDTH = HEADER_BYTES * 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SEND   = 3'd2,
    ST_DONE   = 3'd3
`ifdef DESCRIPTOR_STREAM_HEADER_EN
    ,
    ST_HEADER = 3'd4
`endif
  } streamer_state_t;

endpackage

// File: rtl/byte_serializer.sv
// ---------------------------------------------------------------------------
// byte_serializer
// Parallel-load shift register that presents its contents one byte at a time,
// MSB first. Used for both header and descriptor words; the caller supplies
// the index of the last byte with each load, so shorter payloads are loaded
// left-aligned.
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   i_load           : load i_data / i_last_idx, restart at byte 0
//   i_data           : parallel word (left-aligned payload)
//   i_last_idx       : index of the final byte of this payload
//   i_shift          : current byte has been transferred, advance
//   o_byte           : current byte
//   o_last           : current byte is the final one of the payload
// ---------------------------------------------------------------------------
module byte_serializer #(
  parameter  int WIDTH = 24,
  localparam int NB    = WIDTH / 8,
  localparam int IW    = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic [IW-1:0]    i_last_idx,
  input  logic             i_shift,
  output logic [7:0]       o_byte,
  output logic             o_last
);

  logic [WIDTH-1:0] r_shift;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    r_last_idx;

  // Load has priority: a new payload always restarts at its first byte.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_shift    <= '0;
      r_idx      <= '0;
      r_last_idx <= '0;
    end else if (i_load) begin
      r_shift    <= i_data;
      r_idx      <= '0;
      r_last_idx <= i_last_idx;
    end else if (i_shift) begin
      r_shift <= r_shift << 8;
      r_idx   <= r_idx + 1'b1;
    end
  end

  assign o_byte = r_shift[WIDTH-1 -: 8];
  assign o_last = (r_idx == r_last_idx);

endmodule

// File: rtl/descriptor_streamer.sv
// ---------------------------------------------------------------------------
// descriptor_streamer
// Reads the descriptor BRAM word by word after the generator finishes and
// serializes each word into bytes (MSB first) on a valid/ready byte port.
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   start            : one-cycle stream request, honoured only in IDLE
//   desc_count       : number of valid words, sampled on an accepted start
//   desc_read_addr   : BRAM read address
//   desc_read_data   : BRAM read data (BRAM_LATENCY cycles after address)
//   byte_out         : current byte (0 when byte_valid is low)
//   byte_valid       : byte_out is valid
//   byte_ready       : sink accepts the byte
//   busy             : FSM not in IDLE
//   stream_done      : one-cycle pulse when the stream completes
// Optional feature macro: DESCRIPTOR_STREAM_HEADER_EN prefixes each stream
// with A5, count[15:8], count[7:0].
// ---------------------------------------------------------------------------
module descriptor_streamer
  import descriptor_pkg::*;
#(
  parameter  int NUMBER_DESCRIPTORS = 4000,
  parameter  int DESC_WIDTH         = DEFAULT_DESC_WIDTH,
  parameter  int BRAM_LATENCY       = 2,
  localparam int AW                 = $clog2(NUMBER_DESCRIPTORS)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  start,
  input  logic [AW-1:0]         desc_count,
  output logic [AW-1:0]         desc_read_addr,
  input  logic [DESC_WIDTH-1:0] desc_read_data,
  output logic [7:0]            byte_out,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  busy,
  output logic                  stream_done
);

  localparam int NBYTES = DESC_WIDTH / 8;
`ifdef DESCRIPTOR_STREAM_HEADER_EN
  localparam int SER_W = (DESC_WIDTH > HEADER_WIDTH) ? DESC_WIDTH : HEADER_WIDTH;
`else
  localparam int SER_W = DESC_WIDTH;
`endif
  localparam int SER_NB = SER_W / 8;
  localparam int IW     = (SER_NB > 1) ? $clog2(SER_NB) : 1;
  localparam int WW     = $clog2(BRAM_LATENCY + 1);

  streamer_state_t r_state;
  streamer_state_t w_next;

  logic [AW-1:0]    r_cnt;
  logic [AW-1:0]    r_addr;
  logic [WW-1:0]    r_wait;

  logic             w_valid;
  logic             w_xfer;
  logic             w_wait_done;
  logic             w_last_word;
  logic             w_ser_load;
  logic [SER_W-1:0] w_ser_data;
  logic [IW-1:0]    w_ser_last_idx;
  logic [7:0]       w_ser_byte;
  logic             w_ser_last;

  assign w_xfer      = w_valid & byte_ready;
  // FETCH lasts BRAM_LATENCY+1 cycles; the data sampled on the final cycle
  // belongs to the address that was set when FETCH was entered.
  assign w_wait_done = (r_wait == WW'(BRAM_LATENCY));
  // Compare addr+1 against cnt so cnt never has to be decremented.
  assign w_last_word = (AW'(r_addr + 1'b1) == r_cnt);

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus serializer control and byte_valid.
  always_comb begin
    w_next         = r_state;
    w_valid        = 1'b0;
    w_ser_load     = 1'b0;
    w_ser_data     = '0;
    w_ser_last_idx = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
`ifdef DESCRIPTOR_STREAM_HEADER_EN
          w_next         = ST_HEADER;
          w_ser_load     = 1'b1;
          w_ser_data     = SER_W'({SYNC_BYTE, 16'(desc_count)}) << (SER_W - HEADER_WIDTH);
          w_ser_last_idx = IW'(HEADER_BYTES - 1);
`else
          w_next = (desc_count == '0) ? ST_DONE : ST_FETCH;
`endif
        end
      end
`ifdef DESCRIPTOR_STREAM_HEADER_EN
      ST_HEADER: begin
        w_valid = 1'b1;
        if (w_xfer && w_ser_last) begin
          w_next = (r_cnt == '0) ? ST_DONE : ST_FETCH;
        end
      end
`endif
      ST_FETCH: begin
        if (w_wait_done) begin
          w_next         = ST_SEND;
          w_ser_load     = 1'b1;
          w_ser_data     = SER_W'(desc_read_data) << (SER_W - DESC_WIDTH);
          w_ser_last_idx = IW'(NBYTES - 1);
        end
      end
      ST_SEND: begin
        w_valid = 1'b1;
        if (w_xfer && w_ser_last) begin
          w_next = w_last_word ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Count latch, read address and BRAM wait counter. The address only moves
  // forward after the final byte of a non-final word, so it never passes
  // cnt-1 and never wraps.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt  <= '0;
      r_addr <= '0;
      r_wait <= '0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_cnt  <= desc_count;
        r_addr <= '0;
      end
      if (r_state == ST_SEND && w_xfer && w_ser_last && !w_last_word) begin
        r_addr <= r_addr + 1'b1;
      end
      if (r_state == ST_FETCH && !w_wait_done) begin
        r_wait <= r_wait + 1'b1;
      end else begin
        r_wait <= '0;
      end
    end
  end

  byte_serializer #(
    .WIDTH(SER_W)
  ) u_serializer (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .i_load     (w_ser_load),
    .i_data     (w_ser_data),
    .i_last_idx (w_ser_last_idx),
    .i_shift    (w_xfer),
    .o_byte     (w_ser_byte),
    .o_last     (w_ser_last)
  );

  assign byte_valid     = w_valid;
  assign byte_out       = w_valid ? w_ser_byte : 8'h00;
  assign busy           = (r_state != ST_IDLE);
  assign stream_done    = (r_state == ST_DONE);
  assign desc_read_addr = r_addr;

endmodule

// File: tb/tb_descriptor_streamer.sv
// ---------------------------------------------------------------------------
// tb_descriptor_streamer
// Scoreboard bench: each stream request pushes the expected byte sequence and
// the completion marker into a queue; a monitor pops and compares whenever
// the DUT transfers a byte or pulses stream_done.
// Optional feature macro: DESCRIPTOR_STREAM_HEADER_EN (expects the header).
// ---------------------------------------------------------------------------
module tb_descriptor_streamer;

  localparam int NUM_DESC = 4000;
  localparam int DW       = 24;
  localparam int LAT      = 2;
  localparam int AW       = $clog2(NUM_DESC);
  localparam int NB       = DW / 8;
`ifdef DESCRIPTOR_STREAM_HEADER_EN
  localparam int HDR = 3;
`else
  localparam int HDR = 0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] desc_count = '0;
  logic [AW-1:0] desc_read_addr;
  logic [DW-1:0] desc_read_data;
  logic [7:0]    byte_out;
  logic          byte_valid;
  logic          byte_ready = 1'b0;
  logic          busy;
  logic          stream_done;

  descriptor_streamer #(
    .NUMBER_DESCRIPTORS(NUM_DESC),
    .DESC_WIDTH        (DW),
    .BRAM_LATENCY      (LAT)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .start         (start),
    .desc_count    (desc_count),
    .desc_read_addr(desc_read_addr),
    .desc_read_data(desc_read_data),
    .byte_out      (byte_out),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .busy          (busy),
    .stream_done   (stream_done)
  );

  always #5 clk_in = ~clk_in;

  // BRAM model with a two-cycle read pipeline.
  logic [DW-1:0] mem [NUM_DESC];
  logic [DW-1:0] rdPipe1;
  logic [DW-1:0] rdPipe2;
  always @(posedge clk_in) begin
    rdPipe1 <= mem[desc_read_addr];
    rdPipe2 <= rdPipe1;
  end
  assign desc_read_data = rdPipe2;

  typedef struct {
    bit         isDone;
    bit         isHdr;
    logic [7:0] data;
    int         addr;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   startCyc = 0;
  int   expDoneCyc = 0;
  int   xferCount = 0;
  int   maxAddr = 0;
  int   readyMode = 0;
  int   phase = 0;
  bit   inStream = 0;
  bit   doneSeen = 0;
  bit   checkTiming = 0;
  bit   prevHold = 0;
  logic [7:0] prevByte = 8'h00;
  logic [3:0] readyPattern = 4'b1001;

  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic void check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  // Sink readiness: always high, the 1,0,0,1 pattern, or random.
  always @(posedge clk_in) begin
    #1;
    case (readyMode)
      0:       byte_ready = 1'b1;
      1: begin
        byte_ready = readyPattern[phase[1:0]];
        phase++;
      end
      default: byte_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on every transfer and done pulse.
  always @(negedge clk_in) begin
    exp_t e;
    if (!rst_n_in) begin
      prevHold = 0;
    end else begin
      if (prevHold) begin
        check(byte_valid == 1'b1, "hold_valid", int'(byte_valid), 1);
        check(byte_out == prevByte, "hold_byte", int'(byte_out), int'(prevByte));
      end
      if (inStream) begin
        check(busy == 1'b1, "busy", int'(busy), 1);
        if (int'(desc_read_addr) > maxAddr) maxAddr = int'(desc_read_addr);
      end
      if (byte_valid && byte_ready) begin
        xferCount++;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL extra_byte: got %0h, required no byte", byte_out);
        end else begin
          e = expQ.pop_front();
          check(!e.isDone && byte_out == e.data, "byte_data", int'(byte_out),
                e.isDone ? 32'h100 : int'(e.data));
          if (!e.isDone && !e.isHdr)
            check(desc_read_addr == AW'(e.addr), "byte_addr", int'(desc_read_addr), e.addr);
        end
      end
      if (stream_done) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL extra_done: got pulse, required none");
        end else begin
          e = expQ.pop_front();
          check(e.isDone, "done_order", 1, int'(e.isDone));
        end
        if (checkTiming) check(cyc == expDoneCyc, "done_cycle", cyc, expDoneCyc);
        doneSeen = 1;
        inStream = 0;
      end
      prevHold = byte_valid && !byte_ready;
      prevByte = byte_out;
    end
  end

  // Build the expected stream from memory contents, then issue start.
  task automatic applyStimulus(input int cnt, input int mode, input bit midStart);
    exp_t e;
`ifdef DESCRIPTOR_STREAM_HEADER_EN
    e.isDone = 0; e.isHdr = 1; e.addr = 0;
    e.data = 8'hA5;        expQ.push_back(e);
    e.data = 8'(cnt >> 8); expQ.push_back(e);
    e.data = 8'(cnt);      expQ.push_back(e);
`endif
    for (int i = 0; i < cnt; i++) begin
      for (int b = 0; b < NB; b++) begin
        e.isDone = 0;
        e.isHdr  = 0;
        e.data   = 8'(mem[i] >> (8 * (NB - 1 - b)));
        e.addr   = i;
        expQ.push_back(e);
      end
    end
    e.isDone = 1; e.isHdr = 0; e.data = 8'h00; e.addr = 0;
    expQ.push_back(e);
    readyMode   = mode;
    checkTiming = (mode == 0);
    doneSeen    = 0;
    xferCount   = 0;
    maxAddr     = 0;
    @(negedge clk_in);
    start      = 1'b1;
    desc_count = AW'(cnt);
    @(posedge clk_in);
    #1;
    start      = 1'b0;
    desc_count = AW'($urandom_range(0, NUM_DESC - 1));
    startCyc   = cyc;
    expDoneCyc = startCyc + HDR + cnt * (NB + LAT + 1);
    inStream   = 1;
    if (midStart) begin
      repeat (4) @(posedge clk_in);
      #1;
      start      = 1'b1;
      desc_count = AW'(5);
      @(posedge clk_in);
      #1;
      start = 1'b0;
    end
  endtask

  // Wait (bounded) for completion, then check totals and return to idle.
  task automatic checkOutput(input int cnt, input string tag);
    int waited = 0;
    while (!doneSeen && waited < 10 * (cnt + 2) + 100) begin
      @(negedge clk_in);
      #1;
      waited++;
    end
    check(doneSeen, {tag, "_done_seen"}, int'(doneSeen), 1);
    check(expQ.size() == 0, {tag, "_queue_empty"}, expQ.size(), 0);
    check(xferCount == HDR + cnt * NB, {tag, "_byte_count"}, xferCount, HDR + cnt * NB);
    check(maxAddr == ((cnt > 0) ? cnt - 1 : 0), {tag, "_max_addr"}, maxAddr,
          (cnt > 0) ? cnt - 1 : 0);
    @(negedge clk_in);
    check(busy == 1'b0 && stream_done == 1'b0, {tag, "_idle_after"},
          int'({busy, stream_done}), 0);
    expQ.delete();
    inStream = 0;
  endtask

  task automatic checkOutputsZero(input string tag);
    check(byte_valid == 1'b0, {tag, "_valid"}, int'(byte_valid), 0);
    check(byte_out == 8'h00, {tag, "_byte"}, int'(byte_out), 0);
    check(busy == 1'b0, {tag, "_busy"}, int'(busy), 0);
    check(stream_done == 1'b0, {tag, "_done"}, int'(stream_done), 0);
    check(desc_read_addr == '0, {tag, "_addr"}, int'(desc_read_addr), 0);
  endtask

  // Reset asserted between edges while byte 2 of word 1 is on the port.
  task automatic resetMidStream();
    int waited = 0;
    applyStimulus(2, 0, 0);
    while (xferCount < HDR + NB + 1 && waited < 100) begin
      @(negedge clk_in);
      #1;
      waited++;
    end
    check(xferCount == HDR + NB + 1, "rst_reach_word1", xferCount, HDR + NB + 1);
    @(posedge clk_in);
    #2;
    rst_n_in = 1'b0;
    #1;
    checkOutputsZero("rst_async");
    expQ.delete();
    inStream    = 0;
    checkTiming = 0;
    @(negedge clk_in);
    #1;
    rst_n_in = 1'b1;
    applyStimulus(2, 0, 0);
    checkOutput(2, "after_reset");
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < NUM_DESC; i++) mem[i] = '0;
    repeat (2) @(negedge clk_in);
    #1;
    checkOutputsZero("reset");
    @(negedge clk_in);
    #1;
    rst_n_in = 1'b1;
    @(negedge clk_in);

    mem[0] = 24'h123456;
    mem[1] = 24'hABCDEF;
    applyStimulus(2, 0, 0);
    checkOutput(2, "basic");
    applyStimulus(2, 1, 0);
    checkOutput(2, "backpressure");
    applyStimulus(0, 0, 0);
    checkOutput(0, "empty");
    applyStimulus(2, 0, 1);
    checkOutput(2, "ignored_start");

    for (int r = 0; r < 6; r++) begin
      cnt = $urandom_range(0, 6);
      for (int i = 0; i < cnt; i++) mem[i] = DW'($urandom);
      applyStimulus(cnt, 2, 0);
      checkOutput(cnt, "random");
    end

    mem[0] = 24'h123456;
    mem[1] = 24'hABCDEF;
    resetMidStream();

    for (int i = 0; i < NUM_DESC; i++) mem[i] = DW'(i);
    applyStimulus(NUM_DESC - 1, 0, 0);
    checkOutput(NUM_DESC - 1, "full_depth");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
